// File: rtl/ws_csr_ctrl_pkg.sv
// Shared types for the writeback-stage CSR initiator: MEM->WB bundle layout,
// CSR request bus layout, CSR op codes and the WB squash state.
package ws_csr_ctrl_pkg;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RD   = 2'b01,
      CSR_OP_WR   = 2'b10,
      CSR_OP_XCHG = 2'b11
   } csr_op_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SQUASH = 1'b1
   } ws_state_e;

   localparam logic [8:0] CSR_ERA   = 9'h006;
   localparam logic [5:0] ECODE_INT = 6'h00;

   // Field order is MSB first and matches the MEM stage packing.
   typedef struct packed {
      logic          ertn;
      logic          ex;
      logic [5:0]    ecode;
      logic [8:0]    esubcode;
      csr_op_e       csr_op;
      logic [8:0]    csr_num;
      logic [31:0]   rj_val;
      logic [31:0]   rkd_val;
      logic          gr_we;
      logic [4:0]    dest;
      logic [31:0]   result;
      logic [31:0]   vaddr;
      logic [31:0]   pc;
   } ms_ws_bus_t;

   typedef struct packed {
      logic [8:0]    num;
      logic          we;
      logic [31:0]   wmask;
      logic [31:0]   wvalue;
   } csr_req_t;

   // The bundle width follows the field list above (194 bits).
   localparam int MS_WS_BUS_WD = $bits(ms_ws_bus_t);
   localparam int CSR_BUS_WD   = $bits(csr_req_t);

endpackage

// File: rtl/ws_csr_ctrl_if.sv
// WB <-> CSR file interface: request bus and commit events out, read data,
// interrupt and exception entry back.
interface ws_csr_ctrl_if
   import ws_csr_ctrl_pkg::*;
();
   logic [CSR_BUS_WD-1:0] ws_to_csr_bus;
   logic [31:0]           csr_rvalue;
   logic                  has_int;
   logic [31:0]           ex_entry;
   logic                  wb_ex;
   logic [5:0]            wb_ecode;
   logic [8:0]            wb_esubcode;
   logic [31:0]           wb_pc;
   logic [31:0]           wb_vaddr;
   logic                  ertn_flush;

   modport master (
      output ws_to_csr_bus, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
      input  csr_rvalue, has_int, ex_entry
   );

   modport slave (
      input  ws_to_csr_bus, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
      output csr_rvalue, has_int, ex_entry
   );
endinterface

// File: rtl/ws_csr_ctrl.sv
// Writeback stage: retires one bundle per cycle, drives CSR requests and
// exception/ertn commits, and squashes the wrong path until the redirect PC arrives.
module ws_csr_ctrl
   import ws_csr_ctrl_pkg::*;
(
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    ms_to_ws_valid,
   output logic                    ws_allowin,
   input  logic [MS_WS_BUS_WD-1:0] ms_to_ws_bus,
   ws_csr_ctrl_if.master           csr_if,
   output logic                    flush_valid,
   output logic [31:0]             flush_target,
   output logic                    rf_we,
   output logic [4:0]              rf_waddr,
   output logic [31:0]             rf_wdata
);

   ws_state_e   r_state;
   logic        r_valid;
   ms_ws_bus_t  r_bus;
   logic [31:0] r_target_q;

   ms_ws_bus_t  w_in;
   logic        w_ready_go;
   logic        w_int;
   logic        w_ex;
   logic        w_ertn;
   logic        w_csr_write;
   csr_req_t    w_req;

   assign w_in       = ms_ws_bus_t'(ms_to_ws_bus);
   assign w_ready_go = 1'b1;
   assign ws_allowin = !r_valid || w_ready_go;

   // Commit priority: interrupt, then bundle exception, then ertn.
   assign w_int       = r_valid && csr_if.has_int;
   assign w_ex        = w_int || (r_valid && r_bus.ex);
   assign w_ertn      = r_valid && !w_ex && r_bus.ertn;
   assign w_csr_write = (r_bus.csr_op == CSR_OP_WR) || (r_bus.csr_op == CSR_OP_XCHG);

   always_comb begin
      w_req = '0;
      if (r_valid) begin
         // ertn reads ERA through the same read port to obtain its return PC.
         w_req.num = w_ertn ? CSR_ERA : r_bus.csr_num;
         w_req.we  = w_csr_write && !w_ex && !w_ertn;
         unique case (r_bus.csr_op)
            CSR_OP_WR: begin
               w_req.wmask  = 32'hFFFF_FFFF;
               w_req.wvalue = r_bus.rkd_val;
            end
            CSR_OP_XCHG: begin
               w_req.wmask  = r_bus.rj_val;
               w_req.wvalue = r_bus.rkd_val;
            end
            default: ;
         endcase
      end
   end

   assign csr_if.ws_to_csr_bus = w_req;
   assign csr_if.wb_ex         = w_ex;
   assign csr_if.ertn_flush    = w_ertn;
   assign csr_if.wb_pc         = r_valid ? r_bus.pc    : 32'h0;
   assign csr_if.wb_vaddr      = r_valid ? r_bus.vaddr : 32'h0;

   always_comb begin
      csr_if.wb_ecode    = '0;
      csr_if.wb_esubcode = '0;
      if (w_ex && !w_int) begin
         csr_if.wb_ecode    = r_bus.ecode;
         csr_if.wb_esubcode = r_bus.esubcode;
      end else if (w_int) begin
         csr_if.wb_ecode    = ECODE_INT;
         csr_if.wb_esubcode = '0;
      end
   end

   assign flush_valid  = w_ex || w_ertn;
   assign flush_target = w_ex ? csr_if.ex_entry : (w_ertn ? csr_if.csr_rvalue : 32'h0);

   assign rf_we    = r_valid && r_bus.gr_we && !w_ex && (r_state == ST_RUN);
   assign rf_waddr = r_valid ? r_bus.dest : 5'd0;
   assign rf_wdata = !r_valid ? 32'h0 :
                     (r_bus.csr_op != CSR_OP_NONE) ? csr_if.csr_rvalue : r_bus.result;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= ST_RUN;
         r_valid    <= 1'b0;
         r_bus      <= '0;
         r_target_q <= '0;
      end else if (flush_valid) begin
         // Anything arriving alongside the flush is younger than the faulting op.
         r_valid    <= 1'b0;
         r_state    <= ST_SQUASH;
         r_target_q <= flush_target;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               r_valid <= ms_to_ws_valid && ws_allowin;
               if (ms_to_ws_valid && ws_allowin)
                  r_bus <= w_in;
            end
            ST_SQUASH: begin
               if (ms_to_ws_valid && (w_in.pc == r_target_q)) begin
                  r_valid <= 1'b1;
                  r_bus   <= w_in;
                  r_state <= ST_RUN;
               end else begin
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_RUN;
            end
         endcase
      end
   end

endmodule
